// File: rtl/led_breathe_multi.sv
// ---------------------------------------------------------------------------
// led_breathe_multi
//
// Multi-channel LED brightness engine. A single free-running timebase PH
// generates a triangle brightness level for every channel; channel i sees
// the timebase shifted by i/CHANNELS of a period. Each channel has a 2-bit
// run mode (OFF / ON / BLINK / BREATHE). In BREATHE the triangle level is
// turned into a pulse density by a first-order sigma-delta modulator.
//
// Parameters
//   CHANNELS     number of LED outputs (power of two, <= 2^(DUTY_W+1))
//   DUTY_W       brightness resolution in bits
//   STEP_W       prescale bits; each level is held for 2^STEP_W cycles
//   DEFAULT_MODE mode loaded into every channel at reset
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   RESYNC     synchronous restart of timebase and modulators
//   MODE_WE    mode write strobe
//   MODE_SEL   channel index for the mode write (out-of-range is ignored)
//   MODE_DATA  mode value: 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   LED        registered LED drive, one bit per channel
//   WRAP       one-cycle pulse while PH = 0 after a wrap or a resync
// ---------------------------------------------------------------------------
module led_breathe_multi #(
    parameter int         CHANNELS     = 4,
    parameter int         DUTY_W       = 5,
    parameter int         STEP_W       = 19,
    parameter logic [1:0] DEFAULT_MODE = 2'b11,
    localparam int        CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RESYNC,
    input  logic                MODE_WE,
    input  logic [CH_W-1:0]     MODE_SEL,
    input  logic [1:0]          MODE_DATA,
    output logic [CHANNELS-1:0] LED,
    output logic                WRAP
);

    localparam int          PH_W   = STEP_W + DUTY_W + 1;
    // Width of the step index (direction bit + level bits).
    localparam int          SEG_W  = DUTY_W + 1;
    // Channel offsets are multiples of 2^STEP_W, so they can be added to
    // the step index directly instead of the full timebase.
    localparam int          SEG_SH = SEG_W - $clog2(CHANNELS);
    localparam int unsigned CH_N   = CHANNELS;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    logic [PH_W-1:0]   ph;
    mode_t             mode      [CHANNELS];
    // Only the residue of the accumulator is stored; its carry bit is the
    // modulator output and is captured directly into LED.
    logic [DUTY_W-1:0] acc       [CHANNELS];

    logic [SEG_W-1:0]  seg;
    logic [DUTY_W-1:0] level;
    logic [DUTY_W:0]   acc_sum   [CHANNELS];
    logic [CHANNELS-1:0] dir;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] acc_clr;
    logic [CHANNELS-1:0] led_next;
    logic              wr_ok;

    // ------------------------------------------------------------------
    // Per-channel triangle level, modulator sum and next LED value
    // ------------------------------------------------------------------
    always_comb begin
        wr_ok    = MODE_WE && (32'(MODE_SEL) < CH_N);
        seg      = '0;
        level    = '0;
        dir      = '0;
        wr_hit   = '0;
        acc_clr  = '0;
        led_next = '0;
        for (int unsigned i = 0; i < CH_N; i++) begin
            acc_sum[i] = '0;
        end

        for (int unsigned i = 0; i < CH_N; i++) begin
            seg    = ph[PH_W-1:STEP_W] + (SEG_W'(i) << SEG_SH);
            dir[i] = seg[SEG_W-1];
            // First half of the period counts down from full scale,
            // second half counts back up.
            level  = dir[i] ? seg[DUTY_W-1:0] : ~seg[DUTY_W-1:0];

            acc_sum[i] = {1'b0, acc[i]} + {1'b0, level};

            wr_hit[i]  = wr_ok && (MODE_SEL == CH_W'(i));
            // Only a transition into BREATHE restarts the modulator;
            // rewriting BREATHE keeps the running residue.
            acc_clr[i] = RESYNC ||
                         (wr_hit[i] && (MODE_DATA == MODE_BREATHE) &&
                          (mode[i] != MODE_BREATHE));

            unique case (mode[i])
                MODE_OFF:     led_next[i] = 1'b0;
                MODE_ON:      led_next[i] = 1'b1;
                MODE_BLINK:   led_next[i] = dir[i];
                MODE_BREATHE: led_next[i] = acc_sum[i][DUTY_W];
                default:      led_next[i] = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State: timebase, wrap pulse, modes, accumulators, LED drive
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph   <= '0;
            WRAP <= 1'b0;
            LED  <= '0;
            for (int unsigned i = 0; i < CH_N; i++) begin
                mode[i] <= mode_t'(DEFAULT_MODE);
                acc[i]  <= '0;
            end
        end else begin
            ph   <= RESYNC ? '0 : ph + PH_W'(1);
            // A resync landing on the natural wrap still yields one pulse.
            WRAP <= (ph == '1) || RESYNC;
            LED  <= led_next;
            for (int unsigned i = 0; i < CH_N; i++) begin
                if (wr_hit[i]) begin
                    mode[i] <= mode_t'(MODE_DATA);
                end
                acc[i] <= acc_clr[i] ? '0 : acc_sum[i][DUTY_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_led_breathe_multi.sv
// ---------------------------------------------------------------------------
// tb_led_breathe_multi
//
// Bench for led_breathe_multi with CHANNELS=2, DUTY_W=3, STEP_W=3 (period
// 128 cycles, 8 cycles per level). A reference model computes the expected
// LED/WRAP values from the timebase position with plain arithmetic: the
// triangle level is |2*step-15|/2 and the sigma-delta output is high when
// floor(sum_of_levels/8) increments. A second instance with CHANNELS=1
// exercises the out-of-range mode write.
// ---------------------------------------------------------------------------
module tb_led_breathe_multi;

    logic       clk;
    logic       rst_n;
    logic       resync;
    logic       mode_we;
    logic [0:0] mode_sel;
    logic [1:0] mode_data;
    logic [1:0] led;
    logic       wrap;

    logic       one_we;
    logic [0:0] one_sel;
    logic [1:0] one_data;
    logic [0:0] one_led;
    logic       one_wrap;

    int total = 0;
    int bad   = 0;

    led_breathe_multi #(
        .CHANNELS(2),
        .DUTY_W(3),
        .STEP_W(3),
        .DEFAULT_MODE(2'b11)
    ) u_dut (
        .CLK(clk),
        .RST_N(rst_n),
        .RESYNC(resync),
        .MODE_WE(mode_we),
        .MODE_SEL(mode_sel),
        .MODE_DATA(mode_data),
        .LED(led),
        .WRAP(wrap)
    );

    led_breathe_multi #(
        .CHANNELS(1),
        .DUTY_W(3),
        .STEP_W(3),
        .DEFAULT_MODE(2'b01)
    ) u_one (
        .CLK(clk),
        .RST_N(rst_n),
        .RESYNC(1'b0),
        .MODE_WE(one_we),
        .MODE_SEL(one_sel),
        .MODE_DATA(one_data),
        .LED(one_led),
        .WRAP(one_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int tri_level(input int p);
        int v;
        v = 2 * (p / 8) - 15;
        if (v < 0) v = -v;
        return v / 2;
    endfunction

    function automatic int lvl_at(input int ph, input int ch);
        return tri_level((ph + ch * 64) % 128);
    endfunction

    function automatic logic exp_bit(input int ph, input int ch,
                                     input logic [1:0] md, input int s);
        int p;
        int lv;
        p  = (ph + ch * 64) % 128;
        lv = tri_level(p);
        case (md)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return (p >= 64);
            default: return ((s + lv) / 8) > (s / 8);
        endcase
    endfunction

    int         m_ph;
    int         m_s    [2];
    logic [1:0] m_mode [2];
    logic [1:0] exp_led;
    logic       exp_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph      <= 0;
            m_s[0]    <= 0;
            m_s[1]    <= 0;
            m_mode[0] <= 2'b11;
            m_mode[1] <= 2'b11;
            exp_led   <= 2'b00;
            exp_wrap  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_led[i] <= exp_bit(m_ph, i, m_mode[i], m_s[i]);
                if (resync || (mode_we && int'(mode_sel) == i &&
                               mode_data == 2'b11 && m_mode[i] != 2'b11))
                    m_s[i] <= 0;
                else
                    m_s[i] <= m_s[i] + lvl_at(m_ph, i);
            end
            exp_wrap <= (m_ph == 127) || resync;
            if (mode_we) m_mode[mode_sel] <= mode_data;
            m_ph <= resync ? 0 : (m_ph + 1) % 128;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        total++;
        if (led !== exp_led || wrap !== exp_wrap) begin
            bad++;
            $display("FAIL model_cycle t=%0t: got led=%b wrap=%b expected led=%b wrap=%b",
                     $time, led, wrap, exp_led, exp_wrap);
        end
    end

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [0:0] s, input logic [1:0] d);
        mode_we   = 1'b1;
        mode_sel  = s;
        mode_data = d;
        @(negedge clk);
        mode_we   = 1'b0;
    endtask

    task automatic wr_one(input logic [0:0] s, input logic [1:0] d);
        one_we   = 1'b1;
        one_sel  = s;
        one_data = d;
        @(negedge clk);
        one_we   = 1'b0;
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
    endtask

    int   cnt;
    int   n;
    int   t2_want [16] = '{7, 6, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5, 6, 7};
    logic h0 [192];
    logic h1 [192];
    logic [7:0] pat;

    initial begin
        rst_n     = 1'b0;
        resync    = 1'b0;
        mode_we   = 1'b0;
        mode_sel  = '0;
        mode_data = '0;
        one_we    = 1'b0;
        one_sel   = '0;
        one_data  = '0;

        // T1: reset defaults and wrap period
        repeat (5) @(negedge clk);
        check("t1_reset_led", int'(led), 0);
        check("t1_reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            for (int c = 1; c <= 300; c++) begin
                @(negedge clk);
                if (wrap) begin
                    n = c;
                    break;
                end
            end
            check($sformatf("t1_wrap_gap%0d", k), n, 128);
        end

        // T2: breathe density per step on channel 0
        pulse_resync();
        for (int s = 0; s < 16; s++) begin
            cnt = 0;
            repeat (8) begin
                @(negedge clk);
                cnt += int'(led[0]);
            end
            check($sformatf("t2_step%0d", s), cnt, t2_want[s]);
        end

        // T3: blink with phase offset
        wr(0, 2'b10);
        wr(1, 2'b10);
        pulse_resync();
        for (int t = 0; t < 192; t++) begin
            @(negedge clk);
            h0[t] = led[0];
            h1[t] = led[1];
        end
        cnt = 0;
        for (int t = 0; t < 64; t++) cnt += int'(h0[t]);
        check("t3_led0_low_first64", cnt, 0);
        cnt = 0;
        for (int t = 64; t < 128; t++) cnt += int'(h0[t]);
        check("t3_led0_high_next64", cnt, 64);
        cnt = 0;
        for (int t = 64; t < 192; t++) if (h1[t] != h0[t-64]) cnt++;
        check("t3_delay64_mismatches", cnt, 0);

        // T4: mode write latency, and ignored out-of-range write
        wr(1, 2'b00);
        @(negedge clk);
        check("t4_ch1_off", int'(led[1]), 0);
        wr(1, 2'b01);
        check("t4_ch1_write_edge", int'(led[1]), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(led[1]);
        end
        check("t4_ch1_on_cycles", cnt, 10);

        check("t4_one_default_on", int'(one_led), 1);
        wr_one(1, 2'b00);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(one_led);
        end
        check("t4_one_oob_ignored", cnt, 4);
        wr_one(0, 2'b00);
        @(negedge clk);
        check("t4_one_inrange_off", int'(one_led), 0);

        // T5: accumulator clear on entering breathe at level 3
        wr(0, 2'b00);
        pulse_resync();
        repeat (31) @(negedge clk);
        wr(0, 2'b11);
        pat = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pat[k-1] = led[0];
            if (k == 3) begin
                mode_we   = 1'b1;
                mode_sel  = 1'b0;
                mode_data = 2'b11;
            end
            if (k == 4) mode_we = 1'b0;
        end
        check("t5_pattern", int'(pat), 8'b1010_0100);

        // T6: resync at PH=127 yields one wrap, then async reset
        pulse_resync();
        cnt = 0;
        repeat (127) begin
            @(negedge clk);
            cnt += int'(wrap);
        end
        pulse_resync();
        check("t6_wrap_at_collision", int'(wrap), 1);
        cnt += int'(wrap);
        repeat (20) begin
            @(negedge clk);
            cnt += int'(wrap);
        end
        check("t6_single_wrap", cnt, 1);

        wr(0, 2'b01);
        wr(1, 2'b01);
        @(negedge clk);
        check("t6_both_on", int'(led), 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_led", int'(led), 0);
        check("t6_async_wrap", int'(wrap), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_modes_breathe", int'(led), 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resync    = ($urandom_range(0, 199) == 0);
            mode_we   = ($urandom_range(0, 7) == 0);
            mode_sel  = 1'($urandom_range(0, 1));
            mode_data = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        resync  = 1'b0;
        mode_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
